// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA frame-buffer path.
// FB_* describe the down-scaled frame buffer that is replicated
// SCALE x SCALE onto the active display area.
package vga_pkg;
    localparam int H_ACT    = 800;
    localparam int V_ACT    = 600;
    localparam int SCALE    = 4;
    localparam int FB_W     = H_ACT / SCALE;
    localparam int FB_H     = V_ACT / SCALE;
    localparam int FB_DEPTH = FB_W * FB_H;
    localparam int ADDR_W   = 15;
    localparam int DATA_W   = 12;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb12_t;
endpackage

// File: rtl/fb_scan_addr.sv
// Scan-out address generator.
// Tracks the horizontal replication phase and frame-buffer column within a
// line, and the vertical replication count / frame-buffer row across lines.
// The row base address is accumulated rather than multiplied.
// Ports:
//   i_pclk, i_rstn  clock, async active-low reset
//   i_hen, i_ven    active-region enables
//   o_rd_slot       this cycle is a scan-out read slot
//   o_scan_addr     frame-buffer word address for the read slot
module fb_scan_addr #(
    parameter int SCALE  = vga_pkg::SCALE,
    parameter int FB_W   = vga_pkg::FB_W,
    parameter int FB_H   = vga_pkg::FB_H,
    parameter int ADDR_W = vga_pkg::ADDR_W
) (
    input  logic              i_pclk,
    input  logic              i_rstn,
    input  logic              i_hen,
    input  logic              i_ven,
    output logic              o_rd_slot,
    output logic [ADDR_W-1:0] o_scan_addr
);
    import vga_pkg::*;

    localparam int PH_W  = (SCALE > 1) ? $clog2(SCALE) : 1;
    localparam int COL_W = (FB_W > 1) ? $clog2(FB_W) : 1;
    localparam int ROW_W = (FB_H > 1) ? $clog2(FB_H) : 1;
    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(SCALE - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(FB_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(FB_H - 1);

    logic              r_hen_d;
    logic [PH_W-1:0]   r_phase;
    logic [COL_W-1:0]  r_col;
    logic [PH_W-1:0]   r_rep;
    logic [ROW_W-1:0]  r_row;
    logic [ADDR_W-1:0] r_row_base;

    always_ff @(posedge i_pclk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_hen_d    <= 1'b0;
            r_phase    <= '0;
            r_col      <= '0;
            r_rep      <= '0;
            r_row      <= '0;
            r_row_base <= '0;
        end else begin
            r_hen_d <= i_hen;

            if (!i_hen) begin
                r_phase <= '0;
                r_col   <= '0;
            end else if (i_ven) begin
                if (r_phase == PH_LAST) begin
                    r_phase <= '0;
                    r_col   <= (r_col == COL_LAST) ? '0 : r_col + COL_W'(1);
                end else begin
                    r_phase <= r_phase + PH_W'(1);
                end
            end

            if (!i_ven) begin
                r_rep      <= '0;
                r_row      <= '0;
                r_row_base <= '0;
            end else if (r_hen_d && !i_hen) begin
                if (r_rep == PH_LAST) begin
                    r_rep <= '0;
                    // Saturate on the last row so the trailing line end of
                    // the frame never points past the buffer.
                    if (r_row != ROW_LAST) begin
                        r_row      <= r_row + ROW_W'(1);
                        r_row_base <= r_row_base + ADDR_W'(FB_W);
                    end
                end else begin
                    r_rep <= r_rep + PH_W'(1);
                end
            end
        end
    end

    assign o_rd_slot   = i_hen && i_ven && (r_phase == '0);
    assign o_scan_addr = r_row_base + ADDR_W'(r_col);
endmodule

// File: rtl/vga_fb_arbiter.sv
// Frame-buffer arbiter: owns a single-port 1-cycle-latency video RAM.
// Scan-out reads take fixed slots (one per SCALE active pixels); every other
// cycle is granted to the painter write port. Read data is replicated to
// SCALE pixels and emitted with syncs delayed two cycles to line up.
// Ports:
//   pclk, rstn                   clock, async active-low reset
//   hen, ven, hs, vs             timing inputs
//   wr_valid/wr_ready/addr/data  painter write handshake
//   ram_*                        RAM port (rdata valid 1 cycle after read)
//   vga_hs, vga_vs, red/green/blue  delayed syncs and colour
//   frame_start                  pulse one cycle after ven rises
//   wr_err                       sticky out-of-range write flag
module vga_fb_arbiter #(
    parameter int H_ACT  = vga_pkg::H_ACT,
    parameter int V_ACT  = vga_pkg::V_ACT,
    parameter int SCALE  = vga_pkg::SCALE,
    parameter int ADDR_W = vga_pkg::ADDR_W,
    parameter int DATA_W = vga_pkg::DATA_W
) (
    input  logic              pclk,
    input  logic              rstn,
    input  logic              hen,
    input  logic              ven,
    input  logic              hs,
    input  logic              vs,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              vga_hs,
    output logic              vga_vs,
    output logic [3:0]        red,
    output logic [3:0]        green,
    output logic [3:0]        blue,
    output logic              frame_start,
    output logic              wr_err
);
    import vga_pkg::*;

    localparam int FBW   = H_ACT / SCALE;
    localparam int FBH   = V_ACT / SCALE;
    localparam int DEPTH = FBW * FBH;
    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

    logic              r_run;
    logic [ADDR_W-1:0] r_ram_addr;
    logic [DATA_W-1:0] r_ram_wdata;
    logic              r_wr_err;
    logic              r_slot_d;
    logic [DATA_W-1:0] r_pix;
    logic [1:0]        r_act_d;
    logic [1:0]        r_hs_d;
    logic [1:0]        r_vs_d;
    logic              r_ven_d;
    logic              r_fs;

    logic              w_scan_slot;
    logic [ADDR_W-1:0] w_scan_addr;
    logic              w_slot;
    logic              w_xfer;
    logic              w_inr;
    logic              w_wr;
    rgb12_t            w_rgb;

    fb_scan_addr #(
        .SCALE  (SCALE),
        .FB_W   (FBW),
        .FB_H   (FBH),
        .ADDR_W (ADDR_W)
    ) u_scan (
        .i_pclk      (pclk),
        .i_rstn      (rstn),
        .i_hen       (hen),
        .i_ven       (ven),
        .o_rd_slot   (w_scan_slot),
        .o_scan_addr (w_scan_addr)
    );

    // r_run keeps the combinational strobes and grant low while in reset and
    // for the release cycle, so the port is quiet until state is clean.
    assign w_slot   = r_run && w_scan_slot;
    assign wr_ready = r_run && !w_slot;
    assign w_xfer   = wr_valid && wr_ready;
    assign w_inr    = {1'b0, wr_addr} < DEPTH_W;
    assign w_wr     = w_xfer && w_inr;

    assign ram_en    = w_slot || w_wr;
    assign ram_we    = w_wr;
    assign ram_addr  = w_slot ? w_scan_addr : (w_wr ? wr_addr : r_ram_addr);
    assign ram_wdata = w_wr ? wr_data : r_ram_wdata;

    always_ff @(posedge pclk or negedge rstn) begin
        if (!rstn) begin
            r_run       <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
            r_wr_err    <= 1'b0;
            r_slot_d    <= 1'b0;
            r_pix       <= '0;
            r_act_d     <= '0;
            r_hs_d      <= '0;
            r_vs_d      <= '0;
            r_ven_d     <= 1'b0;
            r_fs        <= 1'b0;
        end else begin
            r_run <= 1'b1;
            if (ram_en)
                r_ram_addr <= ram_addr;
            if (w_wr)
                r_ram_wdata <= wr_data;
            if (w_xfer && !w_inr)
                r_wr_err <= 1'b1;
            // RAM returns data the cycle after the slot; capture it then.
            r_slot_d <= w_slot;
            if (r_slot_d)
                r_pix <= ram_rdata;
            r_act_d <= {r_act_d[0], hen && ven};
            r_hs_d  <= {r_hs_d[0], hs};
            r_vs_d  <= {r_vs_d[0], vs};
            r_ven_d <= ven;
            r_fs    <= ven && !r_ven_d;
        end
    end

    assign w_rgb       = r_act_d[1] ? rgb12_t'(r_pix) : '0;
    assign red         = w_rgb.r;
    assign green       = w_rgb.g;
    assign blue        = w_rgb.b;
    assign vga_hs      = r_hs_d[1];
    assign vga_vs      = r_vs_d[1];
    assign frame_start = r_fs;
    assign wr_err      = r_wr_err;
endmodule

// File: tb/tb_vga_fb_arbiter.sv
module tb_vga_fb_arbiter;
    localparam int H_ACT  = 16;
    localparam int V_ACT  = 12;
    localparam int SCALE  = 4;
    localparam int ADDR_W = 15;
    localparam int DATA_W = 12;
    localparam int FBW    = H_ACT / SCALE;
    localparam int DEPTH  = FBW * (V_ACT / SCALE);
    localparam int HB     = 6;
    localparam int VB     = 3;
    localparam int HT     = H_ACT + HB;

    logic pclk = 1'b0, rstn = 1'b0;
    logic hen = 1'b0, ven = 1'b0, hs = 1'b0, vs = 1'b0, wr_valid = 1'b0;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [DATA_W-1:0] wr_data = '0;
    logic wr_ready, ram_en, ram_we, vga_hs, vga_vs, frame_start, wr_err;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata = '0;
    logic [3:0] red, green, blue;

    always #5 pclk = ~pclk;

    vga_fb_arbiter #(.H_ACT(H_ACT), .V_ACT(V_ACT), .SCALE(SCALE),
                     .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .pclk(pclk), .rstn(rstn), .hen(hen), .ven(ven), .hs(hs), .vs(vs),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
        .wr_data(wr_data), .ram_en(ram_en), .ram_we(ram_we),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .vga_hs(vga_hs), .vga_vs(vga_vs), .red(red), .green(green),
        .blue(blue), .frame_start(frame_start), .wr_err(wr_err));

    // Video RAM: single port, read data one cycle after the read.
    logic [DATA_W-1:0] vram [0:(1<<ADDR_W)-1];
    always @(posedge pclk) begin
        if (ram_en) begin
            if (ram_we) vram[ram_addr] <= ram_wdata;
            else        ram_rdata <= vram[ram_addr];
        end
    end

    // Stimulus position (pixel within line, active line index).
    int cur_x = 0, cur_y = 0;
    bit chk_en = 1'b0;

    // Reference model: the frame buffer plus what each displayed pixel shows.
    logic [DATA_W-1:0] fb_ref [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] m_word, h1_word, h2_word, m_last_wdata;
    logic [ADDR_W-1:0] m_last_addr;
    logic h1_act, h2_act, hs1, hs2, vs1, vs2, ven1, ven2, m_err, m_addr_ok;

    function automatic bit f_slot();
        return hen && ven && (cur_x % SCALE == 0);
    endfunction
    function automatic logic [ADDR_W-1:0] f_ra();
        return ADDR_W'((cur_y / SCALE) * FBW + cur_x / SCALE);
    endfunction
    function automatic bit f_wr();
        return wr_valid && !f_slot() && (wr_addr < DEPTH);
    endfunction

    always @(posedge pclk or negedge rstn) begin
        if (!rstn) begin
            m_word <= '0; h1_word <= '0; h2_word <= '0; h1_act <= 0; h2_act <= 0;
            hs1 <= 0; hs2 <= 0; vs1 <= 0; vs2 <= 0; ven1 <= 0; ven2 <= 0;
            m_err <= 0; m_addr_ok <= 0; m_last_addr <= '0; m_last_wdata <= '0;
        end else begin
            m_word  <= f_slot() ? fb_ref[f_ra()] : m_word;
            h1_word <= f_slot() ? fb_ref[f_ra()] : m_word;
            h1_act  <= hen && ven;
            h2_word <= h1_word; h2_act <= h1_act;
            hs1 <= hs; hs2 <= hs1; vs1 <= vs; vs2 <= vs1; ven1 <= ven; ven2 <= ven1;
            if (wr_valid && !f_slot() && !(wr_addr < DEPTH)) m_err <= 1'b1;
            if (f_wr()) begin
                fb_ref[wr_addr] <= wr_data;
                m_last_wdata    <= wr_data;
            end
            if (f_slot())    m_last_addr <= f_ra();
            else if (f_wr()) m_last_addr <= wr_addr;
            if (!chk_en) m_addr_ok <= 1'b0;
            else if (f_slot() || f_wr()) m_addr_ok <= 1'b1;
        end
    end

    int n_chk = 0, n_err = 0;
    int n_low = 0, n_acc = 0, fs_cnt = 0;
    bit last_acc = 0;
    logic [11:0] obs [0:V_ACT-1][0:H_ACT-1];
    logic [11:0] e1 = '0, e2 = '0;
    bit pv1_a = 0, pv2_a = 0;
    int pv1_x = 0, pv1_y = 0, pv2_x = 0, pv2_y = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h @%0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison, run mid-cycle.
    task automatic cmp_cycle();
        bit s, wr;
        logic [ADDR_W-1:0] ea;
        s  = f_slot();
        wr = f_wr();
        last_acc = rstn && wr_valid && wr_ready;
        if (!rstn) begin
            chk("rst_ctl", {wr_ready, ram_en, ram_we, vga_hs, vga_vs, red, green,
                            blue, frame_start, wr_err}, 32'd0);
            chk("rst_ram", {ram_addr, ram_wdata}, 32'd0);
        end else if (chk_en) begin
            chk("wr_ready", wr_ready, !s);
            chk("ram_en", ram_en, s || wr);
            chk("ram_we", ram_we, wr);
            ea = s ? f_ra() : (wr ? wr_addr : m_last_addr);
            if (s || wr || m_addr_ok) chk("ram_addr", ram_addr, ea);
            chk("ram_wdata", ram_wdata, wr ? wr_data : m_last_wdata);
            chk("colour", {red, green, blue}, h2_act ? h2_word : 12'h000);
            chk("vga_hs", vga_hs, hs2);
            chk("vga_vs", vga_vs, vs2);
            chk("frame_start", frame_start, ven1 && !ven2);
            chk("wr_err", wr_err, m_err);
            if (hen && ven && !wr_ready) n_low++;
            if (hen && ven && wr_valid && wr_ready) n_acc++;
            if (frame_start) fs_cnt++;
        end
        if (rstn && hen && ven && cur_y == 0 && cur_x == 1) e1 = {red, green, blue};
        if (rstn && hen && ven && cur_y == 0 && cur_x == 2) e2 = {red, green, blue};
        if (rstn && pv2_a) obs[pv2_y][pv2_x] = {red, green, blue};
        pv2_a = pv1_a; pv2_x = pv1_x; pv2_y = pv1_y;
        pv1_a = hen && ven; pv1_x = cur_x; pv1_y = cur_y;
    endtask

    task automatic tick();
        @(negedge pclk);
        cmp_cycle();
        @(posedge pclk);
        #1;
    endtask

    task automatic paint(input int a, input logic [DATA_W-1:0] d);
        bit got;
        got = 0;
        wr_valid = 1; wr_addr = ADDR_W'(a); wr_data = d;
        for (int k = 0; k < 20 && !got; k++) begin
            tick();
            got = last_acc;
        end
        wr_valid = 0;
        chk("paint_accept", got, 1);
    endtask

    task automatic run_frame(input bit hold, input int rst_ln);
        fs_cnt = 0; n_low = 0; n_acc = 0;
        if (hold) begin wr_valid = 1; wr_addr = 15'd5; wr_data = 12'h5A5; end
        for (int ln = 0; ln < VB + V_ACT; ln++) begin
            for (int px = 0; px < HT; px++) begin
                hen = (px < H_ACT); ven = (ln >= VB);
                hs = (px == H_ACT + 1) || (px == H_ACT + 2); vs = (ln == 1);
                cur_x = px; cur_y = ln - VB;
                if (ln == rst_ln && px == 5) begin rstn = 0; chk_en = 0; end
                if (ln == rst_ln && px == 9) rstn = 1;
                tick();
            end
            if (hold && ln >= VB) begin
                chk("line_rd_slots", n_low, FBW);
                chk("line_wr_acc", n_acc, H_ACT - FBW);
                n_low = 0; n_acc = 0;
            end
        end
        wr_valid = 0;
        if (rst_ln < 0) chk("frame_start_cnt", fs_cnt, 1);
        chk_en = 1;
    endtask

    initial begin
        hen = 1; ven = 1;
        @(posedge pclk); #1;
        repeat (2) tick();
        hen = 0; ven = 0;
        tick();
        rstn = 1;
        tick();
        chk_en = 1;

        paint(0, 12'hF00);
        paint(1, 12'h0F0);
        for (int i = 2; i < 11; i++) paint(i, 12'(i * 12'h111));
        paint(11, 12'h00F);
        run_frame(0, -1);
        chk("px00_red", obs[0][0], 12'hF00);
        chk("px33_red", obs[3][3], 12'hF00);
        chk("px04_word1", obs[0][4], 12'h0F0);
        chk("px37_word1", obs[3][7], 12'h0F0);
        chk("px40_row1", obs[4][0], 12'h444);
        chk("px11_11", obs[11][11], 12'hAAA);
        chk("br_blue_a", obs[11][15], 12'h00F);
        chk("br_blue_b", obs[8][12], 12'h00F);
        chk("edge_plus1", e1, 12'h000);
        chk("edge_plus2", e2, 12'hF00);

        run_frame(1, -1);
        chk("held_write_shown", obs[4][4], 12'h5A5);

        paint(DEPTH, 12'h123);
        chk("wr_err_set", wr_err, 1);
        paint(32'h7FFF, 12'h321);
        run_frame(0, -1);
        chk("wr_err_sticky", wr_err, 1);

        run_frame(0, VB + 5);
        chk("wr_err_cleared", wr_err, 0);
        run_frame(0, -1);
        chk("post_rst_px00", obs[0][0], 12'hF00);
        chk("post_rst_px55", obs[5][6], 12'h5A5);
        chk("post_rst_br", obs[11][15], 12'h00F);
        chk("post_rst_fs", fs_cnt, 1);

        hen = 0; ven = 0; hs = 0; vs = 0;
        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
